// File: rtl/mult_div_ctrl.sv
// EXE-stage multiply/divide sequencer: registered multiplier, 32-step restoring divider,
// and owner of the architectural HI/LO pair, which commits only at hand-off to MEM.
module mult_div_ctrl #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_in,
  input  logic        exe_valid_in,
  input  logic        mem_allowin_in,
  input  logic [5:0]  md_op_in,
  input  logic [31:0] in0_in,
  input  logic [31:0] in1_in,
  output logic        md_ready_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        md_busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_b_q;
  logic        op_signed_q;
  logic [63:0] div_acc_q;
  logic [4:0]  div_cnt_q;
  logic [63:0] pending_q;
  logic [31:0] hi_q, lo_q;

  // Priority decode: MULT > MULTU > DIV > DIVU > MTHI > MTLO.
  logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  assign op_mult  = md_op_in[0];
  assign op_multu = !md_op_in[0] && md_op_in[1];
  assign op_div   = (md_op_in[1:0] == 2'b00) && md_op_in[2];
  assign op_divu  = (md_op_in[2:0] == 3'b000) && md_op_in[3];
  assign op_mthi  = (md_op_in[3:0] == 4'b0000) && md_op_in[4];
  assign op_mtlo  = (md_op_in[4:0] == 5'b00000) && md_op_in[5];

  logic is_mul, is_div, start_req, div_last;
  assign is_mul    = op_mult || op_multu;
  assign is_div    = op_div || op_divu;
  assign start_req = exe_valid_in && (is_mul || is_div);
  assign div_last  = (div_cnt_q == 5'(DIV_STEPS - 1));

  // Multiplier: sign/zero-extend to 64 bits so the low 64 product bits are exact either way.
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = {{32{op_signed_q && op_a_q[31]}}, op_a_q};
  assign mul_b   = {{32{op_signed_q && op_b_q[31]}}, op_b_q};
  assign product = mul_a * mul_b;

  // Divider works on magnitudes; the dividend magnitude is loaded at acceptance.
  logic [31:0] abs_in0, divisor;
  logic [32:0] trial;
  logic [63:0] step_acc;
  assign abs_in0  = (op_div && in0_in[31]) ? -in0_in : in0_in;
  assign divisor  = (op_signed_q && op_b_q[31]) ? -op_b_q : op_b_q;
  assign trial    = div_acc_q[63:31] - {1'b0, divisor};
  assign step_acc = trial[32] ? {div_acc_q[62:0], 1'b0}
                              : {trial[31:0], div_acc_q[30:0], 1'b1};

  logic [31:0] quo, rem, quo_fix, rem_fix;
  logic [63:0] div_result;
  assign quo        = step_acc[31:0];
  assign rem        = step_acc[63:32];
  assign quo_fix    = (op_signed_q && (op_a_q[31] ^ op_b_q[31])) ? -quo : quo;
  assign rem_fix    = (op_signed_q && op_a_q[31]) ? -rem : rem;
  assign div_result = (op_b_q == 32'd0) ? {op_a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: defaults come first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    md_ready_out = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        md_ready_out = !start_req;
        if (start_req) state_d = is_mul ? S_MUL : S_DIV;
      end
      S_MUL:  state_d = S_DONE;
      S_DIV:  if (div_last) state_d = S_DONE;
      S_DONE: begin
        md_ready_out = 1'b1;
        if (mem_allowin_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_in) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_signed_q <= 1'b0;
      div_acc_q   <= '0;
      div_cnt_q   <= '0;
      pending_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_req && !clr_in) begin
          op_a_q      <= in0_in;
          op_b_q      <= in1_in;
          op_signed_q <= op_mult || op_div;
          div_acc_q   <= {32'd0, abs_in0};
          div_cnt_q   <= '0;
        end
        S_MUL: pending_q <= product;
        S_DIV: begin
          div_acc_q <= step_acc;
          div_cnt_q <= div_cnt_q + 5'd1;
          if (div_last) pending_q <= div_result;
        end
        default: ;
      endcase

      // A flush always wins over a commit, so an uncommitted result never reaches HI/LO.
      if (!clr_in) begin
        if (state_q == S_DONE && mem_allowin_in) begin
          hi_q <= pending_q[63:32];
          lo_q <= pending_q[31:0];
        end else if (state_q == S_IDLE && exe_valid_in && mem_allowin_in) begin
          if (op_mthi) hi_q <= in0_in;
          if (op_mtlo) lo_q <= in0_in;
        end
      end
    end
  end

  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign md_busy_out = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: stall lengths, results, divide-by-zero,
// flush and reset aborts, DONE stalls, and MTHI/MTLO writes.
module tb_mult_div_ctrl;

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  logic        clk = 1'b0;
  logic        rst, clr_in, exe_valid_in, mem_allowin_in;
  logic [5:0]  md_op_in;
  logic [31:0] in0_in, in1_in;
  logic        md_ready_out, md_busy_out;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;
  int low;

  mult_div_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .clr_in         (clr_in),
    .exe_valid_in   (exe_valid_in),
    .mem_allowin_in (mem_allowin_in),
    .md_op_in       (md_op_in),
    .in0_in         (in0_in),
    .in1_in         (in1_in),
    .md_ready_out   (md_ready_out),
    .hi_out         (hi_out),
    .lo_out         (lo_out),
    .md_busy_out    (md_busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op with MEM accepting, count cycles with ready low (bounded),
  // then let the commit edge pass and retire the instruction from EXE.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int low_cycles);
    exe_valid_in   = 1'b1;
    md_op_in       = op;
    in0_in         = a;
    in1_in         = b;
    mem_allowin_in = 1'b1;
    #1;
    low_cycles = 0;
    while (!md_ready_out && low_cycles < 100) begin
      tick();
      low_cycles++;
    end
    tick();
    exe_valid_in = 1'b0;
    md_op_in     = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_in = 1'b0; exe_valid_in = 1'b0; mem_allowin_in = 1'b0;
    md_op_in = '0; in0_in = '0; in1_in = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_ready", 32'(md_ready_out), 32'd1);
    check("reset_busy",  32'(md_busy_out),  32'd0);
    check("reset_hi", hi_out, 32'h0);
    check("reset_lo", lo_out, 32'h0);

    // Multiplies
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, low);
    check("mult_low_cycles", 32'(low), 32'd2);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, low);
    check("multu_low_cycles", 32'(low), 32'd2);
    check("multu_hi", hi_out, 32'h0000_0002);
    check("multu_lo", lo_out, 32'hFFFF_FFFA);

    // Divides
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, low);
    check("div_low_cycles", 32'(low), 32'd33);
    check("div_neg_lo", lo_out, 32'hFFFF_FFFD);
    check("div_neg_hi", hi_out, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, low);
    check("div_negdivisor_lo", lo_out, 32'hFFFF_FFFD);
    check("div_negdivisor_hi", hi_out, 32'd1);
    run_op(OP_DIVU, 32'd100, 32'd7, low);
    check("divu_low_cycles", 32'(low), 32'd33);
    check("divu_lo", lo_out, 32'd14);
    check("divu_hi", hi_out, 32'd2);
    run_op(OP_DIVU, 32'h1234, 32'd0, low);
    check("divz_low_cycles", 32'(low), 32'd33);
    check("divz_lo", lo_out, 32'hFFFF_FFFF);
    check("divz_hi", hi_out, 32'h1234);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, low);
    check("div_ovf_lo", lo_out, 32'h8000_0000);
    check("div_ovf_hi", hi_out, 32'h0);

    // MTHI/MTLO preload, then flush a DIV at step 10
    run_op(OP_MTHI, 32'hAAAA, 32'd0, low);
    check("mthi_low_cycles", 32'(low), 32'd0);
    run_op(OP_MTLO, 32'h5555, 32'd0, low);
    check("mthi_hi", hi_out, 32'hAAAA);
    check("mtlo_lo", lo_out, 32'h5555);
    exe_valid_in = 1'b1; md_op_in = OP_DIV; in0_in = 32'd100; in1_in = 32'd7;
    mem_allowin_in = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("clr_busy_before", 32'(md_busy_out), 32'd1);
    check("clr_ready_before", 32'(md_ready_out), 32'd0);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0; exe_valid_in = 1'b0; md_op_in = '0;
    #1;
    check("clr_ready_after", 32'(md_ready_out), 32'd1);
    check("clr_busy_after", 32'(md_busy_out), 32'd0);
    check("clr_hi_kept", hi_out, 32'hAAAA);
    check("clr_lo_kept", lo_out, 32'h5555);

    // DONE stall with MEM blocked
    exe_valid_in = 1'b1; md_op_in = OP_MULT; in0_in = 32'd5; in1_in = 32'd6;
    mem_allowin_in = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", 32'(md_ready_out), 32'd1);
      check("stall_lo_unchanged", lo_out, 32'h5555);
      tick();
    end
    check("stall_busy", 32'(md_busy_out), 32'd1);
    mem_allowin_in = 1'b1;
    tick();
    exe_valid_in = 1'b0; md_op_in = '0;
    #1;
    check("stall_commit_hi", hi_out, 32'd0);
    check("stall_commit_lo", lo_out, 32'd30);

    // Flush coinciding with a DONE commit
    exe_valid_in = 1'b1; md_op_in = OP_MULTU; in0_in = 32'd2; in1_in = 32'd3;
    mem_allowin_in = 1'b0;
    tick(); tick();
    clr_in = 1'b1; mem_allowin_in = 1'b1;
    tick();
    clr_in = 1'b0; exe_valid_in = 1'b0; md_op_in = '0;
    #1;
    check("clr_done_lo", lo_out, 32'd30);
    check("clr_done_busy", 32'(md_busy_out), 32'd0);

    // Flush coinciding with MTHI
    exe_valid_in = 1'b1; md_op_in = OP_MTHI; in0_in = 32'h99; mem_allowin_in = 1'b1;
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0; exe_valid_in = 1'b0; md_op_in = '0;
    #1;
    check("clr_mthi_hi", hi_out, 32'd0);

    // Reset mid-DIV
    run_op(OP_MTHI, 32'h5, 32'd0, low);
    check("pre_rst_hi", hi_out, 32'h5);
    exe_valid_in = 1'b1; md_op_in = OP_DIV; in0_in = 32'd50; in1_in = 32'd3;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; exe_valid_in = 1'b0; md_op_in = '0;
    #1;
    check("rst_mid_busy", 32'(md_busy_out), 32'd0);
    check("rst_mid_hi", hi_out, 32'd0);
    check("rst_mid_lo", lo_out, 32'd0);
    check("rst_mid_ready", 32'(md_ready_out), 32'd1);

    // MTHI after reset: no stall
    run_op(OP_MTHI, 32'h77, 32'd0, low);
    check("mthi77_low_cycles", 32'(low), 32'd0);
    check("mthi77_hi", hi_out, 32'h77);
    check("mthi77_lo", lo_out, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
